aes_mix_columns_engine: RTL

- Sequential, parametrised AES MixColumns / InvMixColumns engine.
- Takes a full 128-bit state over a valid/ready handshake and processes `COLS_PER_CYCLE` columns per clock.
- Computes GF(2^8) products with xtime chains instead of per-coefficient LUTs, so one datapath covers both coefficient sets {02,03,01,01} and {0e,0b,0d,09}.
- Sits between ShiftRows and AddRoundKey in the round datapath, for both cipher and inverse-cipher flows.

---
 rtl/aes_mix_columns_engine_pkg.sv | 42 ++++
 rtl/aes_mix_columns_engine_if.sv | 22 ++
 rtl/aes_mix_columns_engine_mix.sv | 23 ++
 rtl/aes_mix_columns_engine.sv | 89 ++++++++
 4 files changed

// File: rtl/aes_mix_columns_engine_pkg.sv
// GF(2^8) helpers, MixColumns coefficient sets and FSM encoding shared by the
// MixColumns engine and its column datapath.
package aes_gf_pkg;

   localparam logic [7:0]  AES_POLY  = 8'h1b;
   // Row-0 coefficients; row r uses the same set rotated right by r bytes.
   localparam logic [31:0] FWD_COEFS = 32'h02_03_01_01;
   localparam logic [31:0] INV_COEFS = 32'h0e_0b_0d_09;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      BUSY = ST_BUSY,
      DONE = ST_DONE
   } state_e;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
   endfunction

   // Every coefficient in both sets fits in 4 bits, so one x/2x/4x/8x chain
   // serves MixColumns and InvMixColumns alike.
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] c);
      logic [7:0] x2, x4, x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return ({8{c[0]}} & x) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
   endfunction

   function automatic logic [7:0] col_byte(input logic [31:0] col, input int unsigned r);
      return col[31 - 8*r -: 8];
   endfunction

   function automatic logic [31:0] state_col(input logic [127:0] s, input logic [1:0] c);
      return s[127 - 32*32'(c) -: 32];
   endfunction

endpackage

// File: rtl/aes_mix_columns_engine_if.sv
// Valid/ready block transfer bus of the MixColumns engine.
interface aes_mix_columns_engine_if;

   logic         in_valid;
   logic         in_ready;
   logic         in_inv;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;

   modport master (
      output in_valid, in_inv, in_state, out_ready,
      input  in_ready, out_valid, out_state
   );

   modport slave (
      input  in_valid, in_inv, in_state, out_ready,
      output in_ready, out_valid, out_state
   );

endinterface

// File: rtl/aes_mix_columns_engine_mix.sv
// One-column MixColumns / InvMixColumns, purely combinational.
module gf_mix_column
   import aes_gf_pkg::*;
(
   input  logic [31:0] col_i,
   input  logic        inv_i,
   output logic [31:0] col_o
);

   logic [31:0] coefs;

   always_comb begin
      coefs = inv_i ? INV_COEFS : FWD_COEFS;
      col_o = '0;
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned k = 0; k < 4; k++) begin
            col_o[31 - 8*r -: 8] = col_o[31 - 8*r -: 8]
                                 ^ gf_mul(col_byte(col_i, (r + k) % 4), 4'(col_byte(coefs, k)));
         end
      end
   end

endmodule

// File: rtl/aes_mix_columns_engine.sv
// Sequential MixColumns / InvMixColumns engine: accepts a 128-bit state and
// mixes COLS_PER_CYCLE columns per clock in place before presenting it.
module aes_mix_columns_engine
   import aes_gf_pkg::*;
#(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   aes_mix_columns_engine_if.slave  bus
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
      $error("aes_mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   // At 4 columns/cycle the step truncates to 0, so col_q never leaves 0.
   localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

   state_e       state_q, state_d;
   logic [1:0]   col_q, col_d;
   logic         mode_q, mode_d;
   logic [127:0] work_q, work_d;

   logic [31:0]  mix_in  [COLS_PER_CYCLE];
   logic [31:0]  mix_out [COLS_PER_CYCLE];

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
      assign mix_in[g] = state_col(work_q, col_q + 2'(g));

      gf_mix_column u_mix (
         .col_i (mix_in[g]),
         .inv_i (mode_q),
         .col_o (mix_out[g])
      );
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      mode_d  = mode_q;
      work_d  = work_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               work_d  = bus.in_state;
               mode_d  = bus.in_inv;
               col_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
               work_d[127 - 32*(32'(col_q) + g) -: 32] = mix_out[g];
            end
            col_d = col_q + STEP;
            if (col_q == LAST_COL) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_q   <= '0;
         mode_q  <= 1'b0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         mode_q  <= mode_d;
         work_q  <= work_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_state = work_q;

endmodule
